// File: rtl/branch_pkg.sv
// Shared branch definitions: funct3 condition encodings and
// the 2-bit saturating predictor states.
package branch_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_state_e;

   localparam logic [1:0] BHT_RESET = WNT;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating counter next-state function.
// Counts up on taken, down on not taken, clamped at ST / SNT.
module sat_counter2
   import branch_pkg::*;
(
   input  logic [1:0] cur,
   input  logic       taken,
   output logic [1:0] nxt
);

   always_comb begin
      nxt = cur;
      unique case (1'b1)
         (taken && (cur != ST)):   nxt = cur + 2'd1;
         (!taken && (cur != SNT)): nxt = cur - 2'd1;
         default:                  nxt = cur;
      endcase
   end

endmodule

// File: rtl/branch_predict_resolve.sv
// Bimodal branch predictor with EX-stage branch resolution,
// one-cycle registered redirect and performance counters.
module branch_predict_resolve
   import branch_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_W       = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] if_pc,
   output logic            if_pred_taken,
   input  logic            ex_branch,
   input  logic            ex_flush,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_rs1,
   input  logic [XLEN-1:0] ex_rs2,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_imm,
   input  logic            ex_pred_taken,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] mispred_count
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic [1:0]       bht [BHT_ENTRIES];
   logic [IDX_W-1:0] if_idx;
   logic [IDX_W-1:0] ex_idx;
   logic [1:0]       ex_cur;
   logic [1:0]       ex_nxt;

   logic            resolve;
   logic            eq;
   logic            lt_s;
   logic            lt_u;
   logic            actual_taken;
   logic            mispredict;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] fallthrough;

   // Only the index bits of if_pc feed the table.
   logic unused_if_pc;
   assign unused_if_pc = ^if_pc;

   assign if_idx = if_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];

   // Lookup reads the current table; same-cycle updates are not bypassed.
   assign if_pred_taken = bht[if_idx][1];

   assign resolve = ex_branch && !ex_flush;

   assign eq   = (ex_rs1 == ex_rs2);
   assign lt_s = ($signed(ex_rs1) < $signed(ex_rs2));
   assign lt_u = (ex_rs1 < ex_rs2);

   always_comb begin
      actual_taken = 1'b0;
      unique case (1'b1)
         (ex_funct3 == F3_BEQ):  actual_taken = eq;
         (ex_funct3 == F3_BNE):  actual_taken = !eq;
         (ex_funct3 == F3_BLT):  actual_taken = lt_s;
         (ex_funct3 == F3_BGE):  actual_taken = !lt_s;
         (ex_funct3 == F3_BLTU): actual_taken = lt_u;
         (ex_funct3 == F3_BGEU): actual_taken = !lt_u;
         default:                actual_taken = 1'b0;
      endcase
   end

   assign mispredict  = actual_taken ^ ex_pred_taken;
   assign target      = ex_pc + ex_imm;
   assign fallthrough = ex_pc + XLEN'(4);

   assign ex_cur = bht[ex_idx];

   sat_counter2 u_sat (
      .cur   (ex_cur),
      .taken (actual_taken),
      .nxt   (ex_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         br_count       <= '0;
         mispred_count  <= '0;
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht[i] <= BHT_RESET;
         end
      end else begin
         redirect_valid <= resolve && mispredict;
         if (resolve) begin
            br_count    <= br_count + CNT_W'(1);
            bht[ex_idx] <= ex_nxt;
            if (mispredict) begin
               mispred_count <= mispred_count + CNT_W'(1);
               redirect_pc   <= actual_taken ? target : fallthrough;
            end
         end
      end
   end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Scoreboard bench for branch_predict_resolve: a reference model
// queues expected state per driven cycle, tests pop and compare.
module tb_branch_predict_resolve;

   logic        clk;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic        ex_branch;
   logic        ex_flush;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_rs1;
   logic [31:0] ex_rs2;
   logic [31:0] ex_pc;
   logic [31:0] ex_imm;
   logic        ex_pred_taken;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] br_count;
   logic [31:0] mispred_count;

   branch_predict_resolve #(
      .XLEN(32), .BHT_ENTRIES(64), .CNT_W(32)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .if_pc          (if_pc),
      .if_pred_taken  (if_pred_taken),
      .ex_branch      (ex_branch),
      .ex_flush       (ex_flush),
      .ex_funct3      (ex_funct3),
      .ex_rs1         (ex_rs1),
      .ex_rs2         (ex_rs2),
      .ex_pc          (ex_pc),
      .ex_imm         (ex_imm),
      .ex_pred_taken  (ex_pred_taken),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .br_count       (br_count),
      .mispred_count  (mispred_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rv;
      logic [31:0] rpc;
      logic [31:0] brc;
      logic [31:0] mpc;
      logic [31:0] pc;
      logic [1:0]  ent;
   } exp_t;

   exp_t        sbq[$];
   logic [1:0]  m_bht [64];
   logic [31:0] m_br;
   logic [31:0] m_mis;
   logic [31:0] m_rpc;
   int          n_checks;
   int          n_fail;

   function automatic logic model_taken(input logic [2:0] f3,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) < $signed(b);
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a < b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_br  = 0;
      m_mis = 0;
      m_rpc = 0;
      for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
   endtask

   task automatic drive_br(input logic br, input logic fl,
                           input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [31:0] imm,
                           input logic pd);
      exp_t e;
      logic act;
      int   ix;
      ex_branch = br; ex_flush = fl; ex_funct3 = f3;
      ex_rs1 = a; ex_rs2 = b; ex_pc = pc; ex_imm = imm;
      ex_pred_taken = pd;
      ix   = int'((pc >> 2) & 32'd63);
      e.rv = 1'b0;
      if (br && !fl) begin
         act  = model_taken(f3, a, b);
         m_br = m_br + 1;
         if (act != pd) begin
            m_mis = m_mis + 1;
            m_rpc = act ? pc + imm : pc + 32'd4;
            e.rv  = 1'b1;
         end
         if (act && m_bht[ix] != 2'b11) m_bht[ix] = m_bht[ix] + 2'd1;
         else if (!act && m_bht[ix] != 2'b00) m_bht[ix] = m_bht[ix] - 2'd1;
      end
      e.rpc = m_rpc; e.brc = m_br; e.mpc = m_mis;
      e.pc  = pc;    e.ent = m_bht[ix];
      sbq.push_back(e);
      @(posedge clk); #1;
      ex_branch = 1'b0;
      ex_flush  = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({redirect_valid, redirect_pc, br_count, mispred_count} !== 97'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rv=%0b rpc=%h br=%0d mis=%0d want all 0",
                  redirect_valid, redirect_pc, br_count, mispred_count);
      end
      if_pc = 32'h100; #1;
      n_checks++;
      if (if_pred_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pred: got %0b want 0", if_pred_taken);
      end
   endtask

   task automatic test_beq();
      exp_t e;
      drive_br(1, 0, 3'd0, 5, 5, 32'h100, 32'h20, 0);
      e = sbq.pop_front(); if_pc = e.pc; #1;
      n_checks++;
      if ({redirect_valid, redirect_pc, br_count, mispred_count, if_pred_taken} !==
          {e.rv, e.rpc, e.brc, e.mpc, e.ent[1]} || redirect_pc !== 32'h120) begin
         n_fail++;
         $display("FAIL beq_redirect: got rv=%0b rpc=%h br=%0d mis=%0d pred=%0b want rv=%0b rpc=%h br=%0d mis=%0d pred=%0b",
                  redirect_valid, redirect_pc, br_count, mispred_count, if_pred_taken,
                  e.rv, e.rpc, e.brc, e.mpc, e.ent[1]);
      end
      drive_br(0, 0, 3'd0, 0, 0, 32'h100, 0, 0);
      e = sbq.pop_front(); #1;
      n_checks++;
      if ({redirect_valid, redirect_pc, br_count, mispred_count} !==
          {e.rv, e.rpc, e.brc, e.mpc}) begin
         n_fail++;
         $display("FAIL beq_one_cycle: got rv=%0b rpc=%h want rv=%0b rpc=%h",
                  redirect_valid, redirect_pc, e.rv, e.rpc);
      end
   endtask

   task automatic test_signed_unsigned();
      exp_t e;
      drive_br(1, 0, 3'd4, 32'hFFFF_FFFF, 1, 32'h104, 32'h40, 1);
      e = sbq.pop_front(); if_pc = e.pc; #1;
      n_checks++;
      if ({redirect_valid, redirect_pc, br_count, mispred_count, if_pred_taken} !==
          {e.rv, e.rpc, e.brc, e.mpc, e.ent[1]}) begin
         n_fail++;
         $display("FAIL blt_taken: got rv=%0b rpc=%h br=%0d mis=%0d want rv=%0b rpc=%h br=%0d mis=%0d",
                  redirect_valid, redirect_pc, br_count, mispred_count,
                  e.rv, e.rpc, e.brc, e.mpc);
      end
      drive_br(1, 0, 3'd6, 32'hFFFF_FFFF, 1, 32'h108, 32'h40, 1);
      e = sbq.pop_front(); if_pc = e.pc; #1;
      n_checks++;
      if ({redirect_valid, redirect_pc, br_count, mispred_count, if_pred_taken} !==
          {e.rv, e.rpc, e.brc, e.mpc, e.ent[1]} || redirect_pc !== 32'h10C) begin
         n_fail++;
         $display("FAIL bltu_fallthrough: got rv=%0b rpc=%h mis=%0d want rv=%0b rpc=%h mis=%0d",
                  redirect_valid, redirect_pc, mispred_count, e.rv, e.rpc, e.mpc);
      end
   endtask

   task automatic test_saturate();
      exp_t e;
      logic t;
      for (int k = 0; k < 10; k++) begin
         t = (k < 5 || k == 9);
         if (t) drive_br(1, 0, 3'd0, 3, 3, 32'h10C, 32'h8, 1);
         else   drive_br(1, 0, 3'd1, 3, 3, 32'h10C, 32'h8, 1);
         e = sbq.pop_front(); if_pc = e.pc; #1;
         n_checks++;
         if ({redirect_valid, redirect_pc, br_count, mispred_count, if_pred_taken} !==
             {e.rv, e.rpc, e.brc, e.mpc, e.ent[1]}) begin
            n_fail++;
            $display("FAIL saturate_%0d: got rv=%0b rpc=%h mis=%0d pred=%0b want rv=%0b rpc=%h mis=%0d pred=%0b",
                     k, redirect_valid, redirect_pc, mispred_count, if_pred_taken,
                     e.rv, e.rpc, e.mpc, e.ent[1]);
         end
      end
   endtask

   task automatic test_funct3();
      exp_t e;
      logic [31:0] av [2];
      logic [31:0] bv [2];
      av[0] = 32'd7;         bv[0] = 32'd7;
      av[1] = 32'h8000_0000; bv[1] = 32'd5;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 8; i++) begin
            drive_br(1, 0, 3'(i), av[p], bv[p], 32'h140 + 32'(4 * i),
                     32'hFFFF_FFF0, 1'($urandom_range(0, 1)));
            e = sbq.pop_front(); if_pc = e.pc; #1;
            n_checks++;
            if ({redirect_valid, redirect_pc, br_count, mispred_count, if_pred_taken} !==
                {e.rv, e.rpc, e.brc, e.mpc, e.ent[1]}) begin
               n_fail++;
               $display("FAIL funct3_%0d_%0d: got rv=%0b rpc=%h mis=%0d pred=%0b want rv=%0b rpc=%h mis=%0d pred=%0b",
                        i, p, redirect_valid, redirect_pc, mispred_count, if_pred_taken,
                        e.rv, e.rpc, e.mpc, e.ent[1]);
            end
         end
      end
   endtask

   task automatic test_flush();
      exp_t e;
      drive_br(1, 1, 3'd0, 9, 9, 32'h110, 32'h80, 0);
      e = sbq.pop_front(); if_pc = e.pc; #1;
      n_checks++;
      if ({redirect_valid, redirect_pc, br_count, mispred_count, if_pred_taken} !==
          {e.rv, e.rpc, e.brc, e.mpc, e.ent[1]}) begin
         n_fail++;
         $display("FAIL flush_ignored: got rv=%0b rpc=%h br=%0d mis=%0d want rv=%0b rpc=%h br=%0d mis=%0d",
                  redirect_valid, redirect_pc, br_count, mispred_count,
                  e.rv, e.rpc, e.brc, e.mpc);
      end
      drive_br(1, 0, 3'd1, 9, 9, 32'h110, 32'h80, 0);
      e = sbq.pop_front(); if_pc = e.pc; #1;
      n_checks++;
      if (if_pred_taken !== e.ent[1] || e.ent !== 2'b00) begin
         n_fail++;
         $display("FAIL flush_bht: got pred=%0b want pred=%0b ent=%0d",
                  if_pred_taken, e.ent[1], e.ent);
      end
   endtask

   task automatic test_same_index();
      exp_t e;
      logic old;
      old   = m_bht[5][1];
      if_pc = 32'h114;
      fork
         drive_br(1, 0, 3'd0, 1, 1, 32'h114, 32'h10, 0);
         begin
            #2;
            n_checks++;
            if (if_pred_taken !== old) begin
               n_fail++;
               $display("FAIL same_index_old: got %0b want %0b", if_pred_taken, old);
            end
         end
      join
      e = sbq.pop_front(); #1;
      n_checks++;
      if (if_pred_taken !== e.ent[1] || e.ent[1] === old) begin
         n_fail++;
         $display("FAIL same_index_new: got %0b want %0b", if_pred_taken, e.ent[1]);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [2:0] ops [6];
      ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd4;
      ops[3] = 3'd5; ops[4] = 3'd6; ops[5] = 3'd7;
      for (int k = 0; k < 12; k++) begin
         drive_br(1, 0, ops[$urandom_range(0, 5)],
                  32'($urandom_range(0, 3)) - 32'd1, 32'($urandom_range(0, 3)),
                  32'h180 + 32'(4 * (k % 8)), 32'($urandom_range(0, 255)) << 2,
                  1'($urandom_range(0, 1)));
         e = sbq.pop_front(); if_pc = e.pc; #1;
         n_checks++;
         if ({redirect_valid, redirect_pc, br_count, mispred_count, if_pred_taken} !==
             {e.rv, e.rpc, e.brc, e.mpc, e.ent[1]}) begin
            n_fail++;
            $display("FAIL b2b_%0d: got rv=%0b rpc=%h br=%0d mis=%0d pred=%0b want rv=%0b rpc=%h br=%0d mis=%0d pred=%0b",
                     k, redirect_valid, redirect_pc, br_count, mispred_count, if_pred_taken,
                     e.rv, e.rpc, e.brc, e.mpc, e.ent[1]);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      drive_br(1, 0, 3'd1, 1, 2, 32'h118, 32'h8, 0);
      e = sbq.pop_front(); #1;
      n_checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== e.rpc) begin
         n_fail++;
         $display("FAIL midreset_pre: got rv=%0b rpc=%h want rv=1 rpc=%h",
                  redirect_valid, redirect_pc, e.rpc);
      end
      rst_n = 1'b0; #1;
      model_reset();
      n_checks++;
      if ({redirect_valid, redirect_pc, br_count, mispred_count} !== 97'd0) begin
         n_fail++;
         $display("FAIL midreset_clear: got rv=%0b rpc=%h br=%0d mis=%0d want all 0",
                  redirect_valid, redirect_pc, br_count, mispred_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive_br(1, 0, 3'd0, 4, 4, 32'h118, 32'h8, 0);
      e = sbq.pop_front(); if_pc = e.pc; #1;
      n_checks++;
      if ({redirect_valid, redirect_pc, br_count, mispred_count, if_pred_taken} !==
          {e.rv, e.rpc, e.brc, e.mpc, e.ent[1]}) begin
         n_fail++;
         $display("FAIL postreset_first: got rv=%0b rpc=%h br=%0d mis=%0d want rv=%0b rpc=%h br=%0d mis=%0d",
                  redirect_valid, redirect_pc, br_count, mispred_count,
                  e.rv, e.rpc, e.brc, e.mpc);
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      rst_n = 1'b0; if_pc = '0;
      ex_branch = 0; ex_flush = 0; ex_funct3 = '0;
      ex_rs1 = '0; ex_rs2 = '0; ex_pc = '0; ex_imm = '0;
      ex_pred_taken = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_beq();
      test_signed_unsigned();
      test_saturate();
      test_funct3();
      test_flush();
      test_same_index();
      test_back_to_back();
      test_reset_mid();
      n_checks++;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sbq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_predict_resolve.md
BRANCH_PREDICT_RESOLVE -- requirements
Module: branch_predict_resolve

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data and PC width in bits.
REQ-002 SHALL have parameter BHT_ENTRIES, default 64, power of two, meaning the number of 2-bit predictor entries.
REQ-003 SHALL have parameter CNT_W, default 32, meaning the width of each performance counter.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 if_pc  input  XLEN  fetch PC to predict.
REQ-007 if_pred_taken  output  1  prediction for if_pc.
REQ-008 ex_branch  input  1  EX stage holds a valid conditional branch.
REQ-009 ex_flush  input  1  EX instruction is squashed; ignore it.
REQ-010 ex_funct3  input  3  branch condition selector.
REQ-011 ex_rs1, ex_rs2  input  XLEN  each  compare operands.
REQ-012 ex_pc  input  XLEN  PC of the branch.
REQ-013 ex_imm  input  XLEN  sign-extended branch offset.
REQ-014 ex_pred_taken  input  1  prediction carried down the pipe with the branch.
REQ-015 redirect_valid  output  1  registered; fetch must redirect.
REQ-016 redirect_pc  output  XLEN  registered redirect target.
REQ-017 br_count  output  CNT_W  resolved branches.
REQ-018 mispred_count  output  CNT_W  mispredicted branches.

Function
REQ-019 SHALL form the BHT index as pc[log2(BHT_ENTRIES)+1:2] for both lookup and update.
REQ-020 SHALL drive if_pred_taken combinationally as bit 1 of bht[idx(if_pc)].
REQ-021 SHALL compute actual_taken from ex_funct3: 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge; 010/011 not taken.
REQ-022 SHALL treat a branch as resolving in a cycle when ex_branch=1 and ex_flush=0; all other cycles are idle.
REQ-023 SHALL compute target = ex_pc + ex_imm and fallthrough = ex_pc + 4, both modulo 2^XLEN.
REQ-024 SHALL define mispredict = actual_taken XOR ex_pred_taken on a resolving cycle.
REQ-025 SHALL, on the clock edge after a resolving mispredict, assert redirect_valid for exactly one cycle, with redirect_pc = target if actual_taken, else fallthrough.
REQ-026 SHALL hold redirect_valid at 0 and redirect_pc at its previous value after idle or correctly predicted cycles.
REQ-027 SHALL, on a resolving cycle, update bht[idx(ex_pc)]: if taken, increment saturating at 11; if not taken, decrement saturating at 00.
REQ-028 SHALL give if_pred_taken the pre-update entry value when lookup and update hit the same index in the same cycle; there is no bypass.
REQ-029 SHALL increment br_count on every resolving cycle, and increment mispred_count on every resolving mispredict; both wrap modulo 2^CNT_W.
REQ-030 SHALL, when ex_flush=1 with ex_branch=1, leave the BHT, the counters and redirect_valid unchanged.
REQ-031 SHALL accept a resolving branch in every cycle, with no back-pressure and no stall.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously force redirect_valid=0, redirect_pc=0, br_count=0, mispred_count=0, and every BHT entry to 01 (weakly not taken).
REQ-033 SHALL discard an in-flight redirect when reset is asserted mid-operation; the first resolution is accepted on the first rising edge after reset deassertion.

Structure
REQ-034 SHALL take the funct3 encodings and the 2-bit counter state constants (SNT=00, WNT=01, WT=10, ST=11) from a shared package, branch_pkg.
REQ-035 SHALL implement the saturating 2-bit update as one sub-module, sat_counter2, with a combinational next-state function.
REQ-036 SHALL keep the compare logic in this module; it replaces the earlier combinational branch unit.

Verification
REQ-037 Reset followed by a lookup of if_pc=0x100 -> if_pred_taken=0; counts 0; redirect_valid=0.
REQ-038 BEQ with rs1=rs2=5, pc=0x100, imm=0x20, pred=0 -> next cycle redirect_valid=1, redirect_pc=0x120; mispred_count=1; entry moves to 10.
REQ-039 BLT with rs1=0xFFFFFFFF, rs2=1, pred=1 -> taken, no redirect; BLTU with the same operands, pred=1 -> redirect_pc=pc+4.
REQ-040 Four taken resolutions at one index -> entry saturates at 11; a fifth taken resolution leaves it at 11; three not-taken resolutions -> 00.
REQ-041 ex_branch=1 with ex_flush=1 and a mispredict -> no redirect, counters unchanged, BHT unchanged.
REQ-042 Lookup and update at the same index in the same cycle -> old prediction returned; the new value is visible next cycle; reset asserted mid-redirect -> redirect_valid=0 immediately.
